f_pc_seq: RTL

Fetch-stage PC sequencer for the pipelined MIPS core. It owns the F-stage PC register and decides each cycle where fetch goes next. Candidates are the exception vector, the ERET return, a D-stage branch/jump/jr target, hold on stall, or PC+4. It also drives the F/D flush, the branch-delay flag for CP0, and fetch-address (AdEL) exception reporting. It sits between the hazard unit, D-stage compare/decode, CP0, and the IM address port.

---
 rtl/f_pc_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/f_pc_seq.sv
// Fetch-stage PC sequencer: owns the F PC register and picks the next
// fetch address from vector, ERET, D-stage redirects, hold or PC+4.
module f_pc_seq #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret_d,
    input  logic [31:0] epc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        d_is_ctrl,
    output logic [31:0] pc,
    output logic        pc_en,
    output logic        flush_fd,
    output logic        f_bd,
    output logic        f_exc,
    output logic [4:0]  f_exc_code,
    output logic [2:0]  npc_src
);

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_J    = 3'd2;
    localparam logic [2:0] SRC_JR   = 3'd3;
    localparam logic [2:0] SRC_ERET = 3'd4;
    localparam logic [2:0] SRC_VEC  = 3'd5;
    localparam logic [2:0] SRC_HOLD = 3'd6;

    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        VEC = 2'd1,
        RET = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_seq;
    logic [2:0]  src_c;
    logic        en_c;
    logic        flush_c;
    logic        run;
    logic        bad_align;
    logic        bad_range;

    // D-stage redirects are only trusted in RUN; VEC/RET hold a bubble in D.
    assign run    = (state_q == RUN);
    assign pc_seq = pc_q + 32'd4;

    // Next-PC priority select: vector > hold > eret > branch > jump > jr > seq.
    always_comb begin
        pc_d    = pc_seq;
        src_c   = SRC_SEQ;
        en_c    = 1'b1;
        flush_c = 1'b0;
        if (req) begin
            pc_d    = EXC_VECTOR;
            src_c   = SRC_VEC;
            flush_c = 1'b1;
        end else if (stall) begin
            pc_d  = pc_q;
            src_c = SRC_HOLD;
            en_c  = 1'b0;
        end else if (run && eret_d) begin
            pc_d    = epc;
            src_c   = SRC_ERET;
            flush_c = 1'b1;
        end else if (run && branch_taken) begin
            pc_d  = branch_target;
            src_c = SRC_BR;
        end else if (run && jump) begin
            pc_d  = jump_target;
            src_c = SRC_J;
        end else if (run && jr) begin
            pc_d  = jr_target;
            src_c = SRC_JR;
        end
    end

    // PC register and redirect-recovery state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            state_q <= RUN;
        end else begin
            if (en_c) begin
                pc_q <= pc_d;
            end
            if (req) begin
                state_q <= VEC;
            end else if (!stall) begin
                case (state_q)
                    RUN:     state_q <= eret_d ? RET : RUN;
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    // A misaligned or out-of-window PC is flagged once it is the fetch address.
    assign bad_align = (pc_q[1:0] != 2'b00);
    assign bad_range = (pc_q < IM_LO) || (pc_q > IM_HI);

    assign pc         = pc_q;
    assign pc_en      = reset ? 1'b1 : en_c;
    assign flush_fd   = !reset && flush_c;
    assign npc_src    = reset ? SRC_SEQ : src_c;
    assign f_bd       = !reset && d_is_ctrl && run && !req && !eret_d;
    assign f_exc      = !reset && (bad_align || bad_range);
    assign f_exc_code = f_exc ? EXC_ADEL : 5'd0;

endmodule
